// File: rtl/adc_sample_capture_if.sv
// Readout port of the capture buffer: the reader presents a logical index,
// the capture block returns the sample one clock later.
interface adc_sample_capture_if #(
  parameter int AW = 8
);
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;

  modport master (output rd_en, output rd_addr, input rd_data);
  modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/adc_sample_capture.sv
// Triggered ADC acquisition: samples on each divided-clock rising edge into a
// circular buffer and freezes a DEPTH-sample record around a level/slope trigger.
module adc_sample_capture #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int PRE   = 64
) (
  input  logic                  clk50,
  input  logic                  rst_n,
  input  logic                  adc_clk,
  input  logic [7:0]            adc_data,
  input  logic                  arm,
  input  logic [7:0]            trig_level,
  input  logic                  trig_slope,
  input  logic                  force_trig,
  adc_sample_capture_if.slave   rd,
  output logic                  busy,
  output logic                  done,
  output logic                  triggered,
  output logic [AW-1:0]         trig_addr,
  output logic [2:0]            state_dbg
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [AW-1:0] PRE_A     = AW'(PRE);
  localparam logic [AW-1:0] PRE_LAST  = AW'(PRE - 1);
  localparam logic [AW-1:0] POST_LAST = AW'(DEPTH - PRE - 2);

  state_t        state, state_n;
  logic          adc_clk_d;
  logic          strobe;
  logic [7:0]    prev;
  logic          prev_valid;
  logic          hit;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] pre_cnt;
  logic [AW-1:0] post_cnt;
  logic          wr_en;
  logic          do_arm;
  logic          take_trig;
  logic [AW-1:0] rd_phys;
  logic [7:0]    rd_data_q;
  logic [7:0]    mem [DEPTH];

  assign strobe = adc_clk & ~adc_clk_d;

  assign hit = prev_valid &&
               (trig_slope ? ((prev > trig_level) && (adc_data <= trig_level))
                           : ((prev < trig_level) && (adc_data >= trig_level)));

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n   = state;
    wr_en     = 1'b0;
    do_arm    = 1'b0;
    take_trig = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        // arm outranks a coincident strobe, so that sample is never written
        if (arm) begin
          do_arm  = 1'b1;
          state_n = ST_PRE;
        end
      end
      ST_PRE: begin
        if (strobe) begin
          wr_en = 1'b1;
          if (pre_cnt == PRE_LAST) state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (strobe) begin
          wr_en = 1'b1;
          if (hit || force_trig) begin
            take_trig = 1'b1;
            state_n   = ST_POST;
          end
        end
      end
      ST_POST: begin
        if (strobe) begin
          wr_en = 1'b1;
          if (post_cnt == POST_LAST) state_n = ST_DONE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      adc_clk_d  <= 1'b1;
      prev       <= '0;
      prev_valid <= 1'b0;
      wr_ptr     <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      trig_addr  <= '0;
      triggered  <= 1'b0;
    end else begin
      adc_clk_d <= adc_clk;
      if (strobe) prev <= adc_data;
      if (do_arm)      prev_valid <= 1'b0;
      else if (strobe) prev_valid <= 1'b1;
      if (do_arm) begin
        wr_ptr    <= '0;
        pre_cnt   <= '0;
        triggered <= 1'b0;
      end else begin
        if (wr_en) wr_ptr <= wr_ptr + AW'(1);
        if (wr_en && state == ST_PRE) pre_cnt <= pre_cnt + AW'(1);
        if (take_trig) begin
          trig_addr <= wr_ptr;
          triggered <= 1'b1;
          post_cnt  <= '0;
        end else if (wr_en && state == ST_POST) begin
          post_cnt <= post_cnt + AW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk50) begin
    if (wr_en) mem[wr_ptr] <= adc_data;
  end

  // rd_en is a bare request with no back-pressure: rd_data is valid exactly one
  // cycle after rd_en and holds its value while rd_en stays low.
  assign rd_phys = trig_addr - PRE_A + rd.rd_addr;

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n)        rd_data_q <= '0;
    else if (rd.rd_en) rd_data_q <= mem[rd_phys];
  end

  assign rd.rd_data = rd_data_q;
  assign busy       = (state == ST_PRE) || (state == ST_WAIT) || (state == ST_POST);
  assign done       = (state == ST_DONE);
  assign state_dbg  = state;

endmodule
